// File: rtl/fetch_if.sv
// Bundle between the fetch stage and its neighbours: imem port, redirect input
// and the decode-side valid/ready instruction stream.
interface fetch_if #(
  parameter int unsigned ADDR_W = 6
);
  logic [ADDR_W-1:0] imem_a;
  logic [31:0]       imem_rd;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              inst_valid;
  logic              inst_ready;
  logic [31:0]       inst;
  logic [31:0]       inst_pc;
  logic [31:0]       pc;

  modport master (
    output imem_a, inst_valid, inst, inst_pc, pc,
    input  imem_rd, redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_a, inst_valid, inst, inst_pc, pc,
    output imem_rd, redirect_valid, redirect_pc, inst_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, imem addressing, a small circular
// prefetch queue and a registered valid/ready output towards decode.
module fetch_unit #(
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input logic      clk,
  input logic      rst_n,
  fetch_if.master  bus
);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [31:0]     pc_q, pc_d;
  logic [31:0]     inst_q [DEPTH];
  logic [31:0]     inst_d [DEPTH];
  logic [31:0]     ipc_q  [DEPTH];
  logic [31:0]     ipc_d  [DEPTH];
  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  logic            pop, push;

  // Pointer wrap is explicit so non-power-of-two depths stay in range.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign bus.imem_a     = pc_q[ADDR_W+1:2];
  assign bus.pc         = pc_q;
  assign bus.inst_valid = (count_q != '0);
  assign bus.inst       = inst_q[head_q];
  assign bus.inst_pc    = ipc_q[head_q];

  assign pop  = bus.inst_valid & bus.inst_ready;
  assign push = ~bus.redirect_valid & ((count_q < CntW'(DEPTH)) | pop);

  always_comb begin
    pc_d    = pc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    inst_d  = inst_q;
    ipc_d   = ipc_q;
    if (bus.redirect_valid) begin
      // Flush wins over any concurrent pop.
      pc_d    = bus.redirect_pc & ~32'h3;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        inst_d[tail_q] = bus.imem_rd;
        ipc_d[tail_q]  = pc_q;
        tail_d         = ptr_inc(tail_q);
        pc_d           = pc_q + 32'd4;
      end
      if (pop) begin
        head_d = ptr_inc(head_q);
      end
      if (push && !pop) begin
        count_d = count_q + CntW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      inst_q  <= '{default: '0};
      ipc_q   <= '{default: '0};
    end else begin
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      inst_q  <= inst_d;
      ipc_q   <= ipc_d;
    end
  end
endmodule
